multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main controller for the multicycle RV32I datapath. Decodes the latched instruction register fields
//  and sequences fetch/decode/execute/memory/writeback through a Moore FSM.
//  Drives every datapath enable and mux select, including imm_sel for the immediate-extension unit
//  (000=I, 001=S, 010=B, 011=J, 100=U). Stalls on a single memory-ready handshake.
// PARAMETERS
//  RESET_STATE  4'd0  state entered on reset (FETCH); fixed, not meant to be overridden
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-high reset
//  op             in   7  instr[6:0] from the instruction register
//  funct3         in   3  instr[14:12]
//  funct7b5       in   1  instr[30]
//  zero           in   1  ALU result == 0
//  lt             in   1  ALU signed rs1<rs2
//  ltu            in   1  ALU unsigned rs1<rs2
//  mem_ready      in   1  memory completes the current access this cycle
//  pc_write       out  1  load PC from result bus
//  adr_src        out  1  memory address: 0=PC, 1=result bus
//  ir_write       out  1  latch instruction register and old PC
//  mem_write      out  1  memory write request
//  reg_write      out  1  register-file write of result bus to rd
//  result_src     out  2  00=ALUOut reg, 01=read data reg, 10=ALU result (combinational)
//  alu_src_a      out  2  00=PC, 01=oldPC, 10=rs1, 11=zero
//  alu_src_b      out  2  00=rs2, 01=imm, 10=const 4
//  alu_control    out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND
//  imm_sel        out  3  immediate format for the extension unit (see PURPOSE)
//  illegal_instr  out  1  one-cycle pulse: unsupported opcode decoded
// BEHAVIOUR
//  - Moore outputs from registered 4-bit state. imm_sel is combinational from op in every state.
//    imm_sel by opcode: I=0000011/0010011/1100111, S=0100011, B=1100011, J=1101111, U=0110111/0010111.
//    Any other opcode gives imm_sel=000.
//  - Reset state and forcing: reset async -> FETCH. While reset=1, pc_write, ir_write, mem_write,
//    reg_write and illegal_instr are forced 0. Selects are 0; alu_control is ADD.
//    Reset mid-instruction abandons the instruction with no partial write.
//  - Defaults in all states: all enables 0, selects 00, alu_control ADD.
//  - FETCH: adr_src=0, src_a=00, src_b=10, result_src=10.
//    pc_write=ir_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
//  - DECODE: src_a=01, src_b=01 (ALUOut<=oldPC+imm, the branch/JAL target). Next state by op:
//      load/store   -> MEMADR
//      0110011      -> EXEC_R
//      0010011      -> EXEC_I
//      1100011      -> BRANCH
//      1101111      -> JAL
//      1100111      -> JALR1
//      0110111/0010111 -> UIMM
//      0001111/1110011 -> FETCH (treated as NOP)
//      other        -> FETCH with illegal_instr=1 for this cycle only
//  - MEMADR: src_a=10, src_b=01. Go to MEMREAD if op[5]=0, else MEMWRITE.
//  - MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then go to MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until mem_ready; that cycle -> FETCH.
//  - EXEC_R: src_a=10, src_b=00 -> ALUWB. EXEC_I: src_a=10, src_b=01 -> ALUWB.
//    alu_control from funct3: 000 ADD (SUB if R-type and funct7b5), 001 SLL, 010 SLT, 011 SLTU,
//    100 XOR, 101 SRL (SRA if funct7b5, both R and I), 110 OR, 111 AND.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BRANCH: src_a=10, src_b=00, SUB, result_src=00, then -> FETCH. pc_write=taken, where taken is:
//      000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu
//    funct3 010/011 is never taken and does not raise illegal_instr.
//  - JAL: src_a=01, src_b=10, result_src=00, pc_write=1 -> ALUWB (rd<=oldPC+4).
//  - JALR1: src_a=10, src_b=01, ADD -> JALR2.
//    JALR2: identical outputs to JAL -> ALUWB. Bit 0 of the jump target is cleared in the datapath.
//  - UIMM: src_a=11 (LUI, op[5]=1) or 01 (AUIPC), src_b=01, ADD -> ALUWB.
//  - Cycle counts with mem_ready always 1:
//      load 5, store 4, R/I 4, U 4, branch 3, JAL 4, JALR 5
//    Each mem_ready=0 cycle adds one cycle.
//  - Unused state codes -> FETCH on the next clock.
// TESTING
//  1 Reset with state at MEMWRITE -> all enables 0 immediately; FETCH on release;
//    no mem_write after release.
//  2 add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALUWB.
//    alu_control=0 in EXEC_R; reg_write=1 only in ALUWB.
//  3 lw (op 0000011) with mem_ready low 2 cycles in MEMREAD -> stays 3 cycles; imm_sel=000 throughout.
//  4 bne (funct3 001): zero=1 -> pc_write=0 in BRANCH; zero=0 -> pc_write=1; imm_sel=010.
//  5 jalr -> FETCH,DECODE,JALR1,JALR2,ALUWB; pc_write only in FETCH and JALR2;
//    lui -> imm_sel=100, alu_src_a=11.
//  6 op 1111111 -> illegal_instr=1 exactly one cycle in DECODE, back to FETCH,
//    no reg_write or mem_write.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore FSM main controller for the multicycle RV32I datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [2:0] imm_sel,
  output logic       illegal_instr
);

  localparam logic [3:0] c_S_FETCH    = 4'd0;
  localparam logic [3:0] c_S_DECODE   = 4'd1;
  localparam logic [3:0] c_S_MEMADR   = 4'd2;
  localparam logic [3:0] c_S_MEMREAD  = 4'd3;
  localparam logic [3:0] c_S_MEMWB    = 4'd4;
  localparam logic [3:0] c_S_MEMWRITE = 4'd5;
  localparam logic [3:0] c_S_EXEC_R   = 4'd6;
  localparam logic [3:0] c_S_EXEC_I   = 4'd7;
  localparam logic [3:0] c_S_ALUWB    = 4'd8;
  localparam logic [3:0] c_S_BRANCH   = 4'd9;
  localparam logic [3:0] c_S_JAL      = 4'd10;
  localparam logic [3:0] c_S_JALR1    = 4'd11;
  localparam logic [3:0] c_S_JALR2    = 4'd12;
  localparam logic [3:0] c_S_UIMM     = 4'd13;

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_B     = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_FENCE = 7'b0001111;
  localparam logic [6:0] c_OP_SYS   = 7'b1110011;

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_SLL  = 4'd2;
  localparam logic [3:0] c_ALU_SLT  = 4'd3;
  localparam logic [3:0] c_ALU_SLTU = 4'd4;
  localparam logic [3:0] c_ALU_XOR  = 4'd5;
  localparam logic [3:0] c_ALU_SRL  = 4'd6;
  localparam logic [3:0] c_ALU_SRA  = 4'd7;
  localparam logic [3:0] c_ALU_OR   = 4'd8;
  localparam logic [3:0] c_ALU_AND  = 4'd9;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pc_write, w_adr_src, w_ir_write, w_mem_write, w_reg_write, w_illegal;
  logic [1:0] w_result_src, w_src_a, w_src_b;
  logic [3:0] w_alu_control;
  logic [3:0] w_alu_fn;
  logic       w_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_next;
  end

  // SUB only exists for R-type; SRA is selected by funct7b5 for both R and I shifts
  always_comb begin
    w_alu_fn = c_ALU_ADD;
    case (funct3)
      3'b000: w_alu_fn = (r_state == c_S_EXEC_R && funct7b5) ? c_ALU_SUB : c_ALU_ADD;
      3'b001: w_alu_fn = c_ALU_SLL;
      3'b010: w_alu_fn = c_ALU_SLT;
      3'b011: w_alu_fn = c_ALU_SLTU;
      3'b100: w_alu_fn = c_ALU_XOR;
      3'b101: w_alu_fn = funct7b5 ? c_ALU_SRA : c_ALU_SRL;
      3'b110: w_alu_fn = c_ALU_OR;
      default: w_alu_fn = c_ALU_AND;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000: w_taken = zero;
      3'b001: w_taken = ~zero;
      3'b100: w_taken = lt;
      3'b101: w_taken = ~lt;
      3'b110: w_taken = ltu;
      3'b111: w_taken = ~ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_sel = 3'b000;
    case (op)
      c_OP_STORE:             imm_sel = 3'b001;
      c_OP_B:                 imm_sel = 3'b010;
      c_OP_JAL:               imm_sel = 3'b011;
      c_OP_LUI, c_OP_AUIPC:   imm_sel = 3'b100;
      default:                imm_sel = 3'b000;
    endcase
  end

  always_comb begin
    w_next = c_S_FETCH;
    case (r_state)
      c_S_FETCH:    w_next = mem_ready ? c_S_DECODE : c_S_FETCH;
      c_S_DECODE: begin
        case (op)
          c_OP_LOAD, c_OP_STORE: w_next = c_S_MEMADR;
          c_OP_R:                w_next = c_S_EXEC_R;
          c_OP_I:                w_next = c_S_EXEC_I;
          c_OP_B:                w_next = c_S_BRANCH;
          c_OP_JAL:              w_next = c_S_JAL;
          c_OP_JALR:             w_next = c_S_JALR1;
          c_OP_LUI, c_OP_AUIPC:  w_next = c_S_UIMM;
          default:               w_next = c_S_FETCH;
        endcase
      end
      c_S_MEMADR:   w_next = op[5] ? c_S_MEMWRITE : c_S_MEMREAD;
      c_S_MEMREAD:  w_next = mem_ready ? c_S_MEMWB : c_S_MEMREAD;
      c_S_MEMWRITE: w_next = mem_ready ? c_S_FETCH : c_S_MEMWRITE;
      c_S_EXEC_R, c_S_EXEC_I, c_S_JAL, c_S_JALR2, c_S_UIMM: w_next = c_S_ALUWB;
      c_S_JALR1:    w_next = c_S_JALR2;
      default:      w_next = c_S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_illegal     = 1'b0;
    w_result_src  = 2'b00;
    w_src_a       = 2'b00;
    w_src_b       = 2'b00;
    w_alu_control = c_ALU_ADD;
    case (r_state)
      c_S_FETCH: begin
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_pc_write   = mem_ready;
        w_ir_write   = mem_ready;
      end
      c_S_DECODE: begin
        w_src_a = 2'b01;
        w_src_b = 2'b01;
        case (op)
          c_OP_LOAD, c_OP_STORE, c_OP_R, c_OP_I, c_OP_B, c_OP_JAL, c_OP_JALR,
          c_OP_LUI, c_OP_AUIPC, c_OP_FENCE, c_OP_SYS: w_illegal = 1'b0;
          default: w_illegal = 1'b1;
        endcase
      end
      c_S_MEMADR: begin
        w_src_a = 2'b10;
        w_src_b = 2'b01;
      end
      c_S_MEMREAD:  w_adr_src = 1'b1;
      c_S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      c_S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_S_EXEC_R: begin
        w_src_a       = 2'b10;
        w_alu_control = w_alu_fn;
      end
      c_S_EXEC_I: begin
        w_src_a       = 2'b10;
        w_src_b       = 2'b01;
        w_alu_control = w_alu_fn;
      end
      c_S_ALUWB:    w_reg_write = 1'b1;
      c_S_BRANCH: begin
        w_src_a       = 2'b10;
        w_alu_control = c_ALU_SUB;
        w_pc_write    = w_taken;
      end
      c_S_JAL, c_S_JALR2: begin
        w_src_a    = 2'b01;
        w_src_b    = 2'b10;
        w_pc_write = 1'b1;
      end
      c_S_JALR1: begin
        w_src_a = 2'b10;
        w_src_b = 2'b01;
      end
      c_S_UIMM: begin
        w_src_a = op[5] ? 2'b11 : 2'b01;
        w_src_b = 2'b01;
      end
      default: ;
    endcase
  end

  // Reset masks every FSM output so an abandoned instruction can never write
  assign pc_write      = ~reset & w_pc_write;
  assign adr_src       = ~reset & w_adr_src;
  assign ir_write      = ~reset & w_ir_write;
  assign mem_write     = ~reset & w_mem_write;
  assign reg_write     = ~reset & w_reg_write;
  assign illegal_instr = ~reset & w_illegal;
  assign result_src    = reset ? 2'b00 : w_result_src;
  assign alu_src_a     = reset ? 2'b00 : w_src_a;
  assign alu_src_b     = reset ? 2'b00 : w_src_b;
  assign alu_control   = reset ? c_ALU_ADD : w_alu_control;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Randomized and directed checks of multicycle_control against a
//            per-instruction step-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_sel;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_sel(imm_sel), .illegal_instr(illegal_instr)
  );

  // {pc_write,adr_src,ir_write,mem_write,reg_write,result_src,src_a,src_b,alu,imm,illegal}
  logic [18:0] w_act;
  assign w_act = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                  alu_src_a, alu_src_b, alu_control, imm_sel, illegal_instr};

  localparam logic [18:0] c_ALL      = 19'h7FFFF;
  localparam logic [18:0] c_NO_IMM   = 19'h7FFF1;

  typedef enum int {K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE,
                    K_EXR, K_EXI, K_ALUWB, K_BRANCH, K_JAL, K_JALR1, K_JALR2, K_UIMM} kind_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  kind_t       steps[$];
  logic [18:0] lg[64];

  task automatic check(input string nm, input logic [18:0] a, input logic [18:0] e,
                       input logic [18:0] m);
    n_cmp++;
    if ((a & m) !== (e & m)) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (mask %h) at %0t", nm, a & m, e & m, m, $time);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  function automatic logic [2:0] m_imm(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [6:0] o);
    logic [6:0] ok[11] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67,
                           7'h37, 7'h17, 7'h0F, 7'h73};
    foreach (ok[i]) if (ok[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_alu(input logic [2:0] f3, input logic f7, input bit is_r);
    int base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int r;
    r = base[f3];
    if (f3 == 3'd0 && is_r && f7) r = 1;
    if (f3 == 3'd5 && f7) r = 7;
    return 4'(r);
  endfunction

  function automatic logic m_taken(input logic [2:0] f3, input logic z, input logic l,
                                   input logic lu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [18:0] m_out(input kind_t k, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7,
                                        input logic mr, input logic z,
                                        input logic l, input logic lu);
    logic pcw, adr, irw, mw, rw, ill;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; alu = 0;
    case (k)
      K_FETCH:    begin sb = 2; rs = 2; pcw = mr; irw = mr; end
      K_DECODE:   begin sa = 1; sb = 1; ill = !m_legal(o); end
      K_MEMADR:   begin sa = 2; sb = 1; end
      K_MEMREAD:  adr = 1;
      K_MEMWB:    begin rs = 1; rw = 1; end
      K_MEMWRITE: begin adr = 1; mw = 1; end
      K_EXR:      begin sa = 2; alu = m_alu(f3, f7, 1'b1); end
      K_EXI:      begin sa = 2; sb = 1; alu = m_alu(f3, f7, 1'b0); end
      K_ALUWB:    rw = 1;
      K_BRANCH:   begin sa = 2; alu = 1; pcw = m_taken(f3, z, l, lu); end
      K_JAL, K_JALR2: begin sa = 1; sb = 2; pcw = 1; end
      K_JALR1:    begin sa = 2; sb = 1; end
      K_UIMM:     begin sa = o[5] ? 2'd3 : 2'd1; sb = 1; end
      default: ;
    endcase
    return {pcw, adr, irw, mw, rw, rs, sa, sb, alu, m_imm(o), ill};
  endfunction

  function automatic void build(input logic [6:0] o);
    steps = '{K_FETCH, K_DECODE};
    case (o)
      7'h03: begin steps.push_back(K_MEMADR); steps.push_back(K_MEMREAD); steps.push_back(K_MEMWB); end
      7'h23: begin steps.push_back(K_MEMADR); steps.push_back(K_MEMWRITE); end
      7'h33: begin steps.push_back(K_EXR); steps.push_back(K_ALUWB); end
      7'h13: begin steps.push_back(K_EXI); steps.push_back(K_ALUWB); end
      7'h63: steps.push_back(K_BRANCH);
      7'h6F: begin steps.push_back(K_JAL); steps.push_back(K_ALUWB); end
      7'h67: begin steps.push_back(K_JALR1); steps.push_back(K_JALR2); steps.push_back(K_ALUWB); end
      7'h37, 7'h17: begin steps.push_back(K_UIMM); steps.push_back(K_ALUWB); end
      default: ;
    endcase
  endfunction

  // Runs one instruction from FETCH; entered and left at posedge+1.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input bit rnd, input int stall, input logic zi,
                           input logic li, input logic lui, output int ncyc);
    kind_t k;
    int    wcnt;
    op = o; funct3 = f3; funct7b5 = f7;
    build(o);
    ncyc = 0; wcnt = 0;
    while (steps.size() > 0 && ncyc < 64) begin
      k = steps[0];
      if (rnd) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        zero = 1'($urandom_range(0, 1));
        lt   = 1'($urandom_range(0, 1));
        ltu  = 1'($urandom_range(0, 1));
      end else begin
        mem_ready = (k == K_FETCH) ? 1'b1 : (wcnt >= stall);
        zero = zi; lt = li; ltu = lui;
      end
      #1;
      check($sformatf("op%b_%s", o, k.name()), w_act,
            m_out(k, o, f3, f7, mem_ready, zero, lt, ltu), c_ALL);
      lg[ncyc] = w_act;
      if (!(k == K_FETCH || k == K_MEMREAD || k == K_MEMWRITE) || mem_ready) begin
        void'(steps.pop_front());
        wcnt = 0;
      end else wcnt++;
      ncyc++;
      @(posedge clk); #1;
    end
    if (steps.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout op%b: got %0d cycles, required completion", o, ncyc);
    end
  endtask

  initial begin
    int n, cnt;
    logic [6:0] ops[13] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67,
                            7'h37, 7'h17, 7'h0F, 7'h73, 7'h7F, 7'h00};
    int   lens[9] = '{5, 4, 4, 4, 3, 4, 5, 4, 4};
    logic [6:0] o;

    reset = 1'b1; op = 7'h33; funct3 = 0; funct7b5 = 0;
    zero = 0; lt = 0; ltu = 0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", w_act, 19'h0, c_NO_IMM);
    reset = 1'b0;

    // add x3,x1,x2
    run_instr(7'h33, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, n);
    check_int("add_cycles", n, 4);
    for (int i = 0; i < 4; i++) check_int($sformatf("add_regwr%0d", i), int'(lg[i][14]), (i == 3) ? 1 : 0);
    check_int("add_alu_exec", int'(lg[2][7:4]), 0);

    // store parked in MEMWRITE, then reset
    op = 7'h23; funct3 = 3'd2; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #1 check_int("memwrite_reached", int'(mem_write), 1);
    #2 reset = 1'b1;
    #1 check("reset_async", w_act, 19'h0, c_NO_IMM);
    mem_ready = 1'b1;
    @(posedge clk); #1 check("reset_held", w_act, 19'h0, c_NO_IMM);
    reset = 1'b0;
    run_instr(7'h33, 3'b111, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, n);
    cnt = 0;
    for (int i = 0; i < n; i++) cnt += int'(lg[i][15]);
    check_int("no_memwrite_after_reset", cnt, 0);

    // lw with two-cycle stall in MEMREAD
    run_instr(7'h03, 3'b010, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, n);
    check_int("lw_cycles", n, 7);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cnt += int'(lg[i][17]);
      check_int($sformatf("lw_imm%0d", i), int'(lg[i][3:1]), 0);
    end
    check_int("lw_memread_cycles", cnt, 3);

    // bne
    run_instr(7'h63, 3'b001, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, n);
    check_int("bne_z1_pcw", int'(lg[2][18]), 0);
    check_int("bne_imm", int'(lg[2][3:1]), 2);
    run_instr(7'h63, 3'b001, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, n);
    check_int("bne_z0_pcw", int'(lg[2][18]), 1);
    check_int("bne_cycles", n, 3);

    // jalr and lui
    run_instr(7'h67, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, n);
    check_int("jalr_cycles", n, 5);
    for (int i = 0; i < 5; i++)
      check_int($sformatf("jalr_pcw%0d", i), int'(lg[i][18]), (i == 0 || i == 3) ? 1 : 0);
    run_instr(7'h37, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, n);
    check_int("lui_imm", int'(lg[2][3:1]), 4);
    check_int("lui_src_a", int'(lg[2][11:10]), 3);

    // illegal opcode
    run_instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, n);
    check_int("illegal_cycles", n, 2);
    check_int("illegal_fetch", int'(lg[0][0]), 0);
    check_int("illegal_decode", int'(lg[1][0]), 1);
    check_int("illegal_writes", int'(lg[0][15:14]) + int'(lg[1][15:14]), 0);

    // per-class cycle counts with memory always ready
    for (int i = 0; i < 9; i++) begin
      run_instr(ops[i], 3'b000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, n);
      check_int($sformatf("len_op%b", ops[i]), n, lens[i]);
    end

    // randomized instruction stream
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 7) == 0) o = 7'($urandom_range(0, 127));
      else o = ops[$urandom_range(0, 12)];
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, 0,
                1'b0, 1'b0, 1'b0, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
